// File: rtl/gpr_operand_fetch_pkg.sv
// Shared constants for the GPR operand fetch stage.
// State encoding, register-file geometry and the zero register index.
package gpr_operand_fetch_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INDEX_WIDTH = 5;

  localparam logic [INDEX_WIDTH-1:0] ZERO_REGISTER_INDEX = '0;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t VALID = 2'd2;

endpackage

// File: rtl/gpr_operand_fetch.sv
// Operand fetch between decode and execute; sole client of the GPR file.
// Port 2 is shared, with writeback taking priority over operand-B reads.
module gpr_operand_fetch #(
  parameter int DATA_WIDTH  = gpr_operand_fetch_pkg::DATA_WIDTH,
  parameter int INDEX_WIDTH = gpr_operand_fetch_pkg::INDEX_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetchValid,
  output logic                   fetchReady,
  input  logic [INDEX_WIDTH-1:0] sourceIndexA,
  input  logic [INDEX_WIDTH-1:0] sourceIndexB,
  output logic                   operandValid,
  input  logic                   operandReady,
  output logic [DATA_WIDTH-1:0]  operandA,
  output logic [DATA_WIDTH-1:0]  operandB,
  input  logic                   writebackValid,
  output logic                   writebackReady,
  input  logic [INDEX_WIDTH-1:0] writebackIndex,
  input  logic [DATA_WIDTH-1:0]  writebackData,
  output logic [INDEX_WIDTH-1:0] gprIndex1,
  input  logic [DATA_WIDTH-1:0]  gprReadData1,
  output logic [INDEX_WIDTH-1:0] gprIndex2,
  input  logic [DATA_WIDTH-1:0]  gprReadData2,
  output logic [DATA_WIDTH-1:0]  gprWriteData2,
  output logic                   gprWriteEnable2
);

  import gpr_operand_fetch_pkg::*;

  state_t                state_q, state_d;
  logic                  zeroA_q, zeroA_d;
  logic                  zeroB_q, zeroB_d;
  logic [DATA_WIDTH-1:0] opA_q, opA_d;
  logic [DATA_WIDTH-1:0] opB_q, opB_d;
  logic                  issue;
  logic                  slotFree;

  assign slotFree = (state_q == IDLE) ||
                    ((state_q == VALID) && operandReady);

  assign fetchReady = !reset && !writebackValid && slotFree;
  assign issue      = fetchValid && fetchReady;

  assign writebackReady  = !reset;
  assign gprIndex1       = sourceIndexA;
  assign gprIndex2       = writebackValid ? writebackIndex
                                          : sourceIndexB;
  assign gprWriteData2   = writebackData;
  assign gprWriteEnable2 = !reset && writebackValid &&
                           (writebackIndex != ZERO_REGISTER_INDEX);

  assign operandValid = (state_q == VALID);
  assign operandA     = opA_q;
  assign operandB     = opB_q;

  always_comb begin
    state_d = state_q;
    zeroA_d = zeroA_q;
    zeroB_d = zeroB_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = READ;
          zeroA_d = (sourceIndexA == ZERO_REGISTER_INDEX);
          zeroB_d = (sourceIndexB == ZERO_REGISTER_INDEX);
        end
      end
      READ: begin
        state_d = VALID;
        opA_d   = zeroA_q ? '0 : gprReadData1;
        opB_d   = zeroB_q ? '0 : gprReadData2;
      end
      VALID: begin
        if (operandReady) begin
          if (issue) begin
            state_d = READ;
            zeroA_d = (sourceIndexA == ZERO_REGISTER_INDEX);
            zeroB_d = (sourceIndexB == ZERO_REGISTER_INDEX);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      zeroA_q <= 1'b0;
      zeroB_q <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
    end else begin
      state_q <= state_d;
      zeroA_q <= zeroA_d;
      zeroB_q <= zeroB_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
    end
  end

endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Bench for gpr_operand_fetch with a behavioural register file,
// directed vector table, hand sequences and randomized traffic.
module tb_gpr_operand_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchValid;
  logic        fetchReady;
  logic [4:0]  sourceIndexA;
  logic [4:0]  sourceIndexB;
  logic        operandValid;
  logic        operandReady;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        writebackValid;
  logic        writebackReady;
  logic [4:0]  writebackIndex;
  logic [31:0] writebackData;
  logic [4:0]  gprIndex1;
  logic [31:0] gprReadData1;
  logic [4:0]  gprIndex2;
  logic [31:0] gprReadData2;
  logic [31:0] gprWriteData2;
  logic        gprWriteEnable2;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] refm [32];
  logic [31:0] rf [32];

  always #5 clock = ~clock;

  gpr_operand_fetch dut (
    .clock(clock),
    .reset(reset),
    .fetchValid(fetchValid),
    .fetchReady(fetchReady),
    .sourceIndexA(sourceIndexA),
    .sourceIndexB(sourceIndexB),
    .operandValid(operandValid),
    .operandReady(operandReady),
    .operandA(operandA),
    .operandB(operandB),
    .writebackValid(writebackValid),
    .writebackReady(writebackReady),
    .writebackIndex(writebackIndex),
    .writebackData(writebackData),
    .gprIndex1(gprIndex1),
    .gprReadData1(gprReadData1),
    .gprIndex2(gprIndex2),
    .gprReadData2(gprReadData2),
    .gprWriteData2(gprWriteData2),
    .gprWriteEnable2(gprWriteEnable2)
  );

  // Register file: synchronous read, write lands at the edge.
  // r0 holds garbage so that the fetch stage must force zero itself.
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[0] = 32'hBAD0BAD0;
  end

  always @(posedge clock) begin
    if (gprWriteEnable2) rf[gprIndex2] <= gprWriteData2;
    gprReadData1 <= rf[gprIndex1];
    gprReadData2 <= rf[gprIndex2];
  end

  typedef struct {
    logic [4:0]  wi;
    logic [31:0] wd;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] i);
    return (i == 5'd0) ? 32'h0 : refm[i];
  endfunction

  task automatic wb_drive(input logic [4:0] i, input logic [31:0] d);
    writebackValid = 1'b1;
    writebackIndex = i;
    writebackData  = d;
  endtask

  task automatic wb_commit;
    if (writebackValid && !reset && writebackIndex != 5'd0)
      refm[writebackIndex] = writebackData;
    writebackValid = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] i, input logic [31:0] d);
    wb_drive(i, d);
    #1;
    chk("wb_ready", {31'b0, writebackReady}, 32'd1);
    chk("wb_we", {31'b0, gprWriteEnable2}, {31'b0, i != 5'd0});
    chk("wb_idx", {27'b0, gprIndex2}, {27'b0, i});
    tick;
    wb_commit();
  endtask

  task automatic fetch_check(input logic [4:0] a, input logic [4:0] b,
                             input logic [31:0] ea, input logic [31:0] eb,
                             input int hold, input bit rnd_wb,
                             input string nm);
    fetchValid   = 1'b1;
    sourceIndexA = a;
    sourceIndexB = b;
    #1;
    chk({nm, ":ready"}, {31'b0, fetchReady}, 32'd1);
    tick;
    fetchValid = 1'b0;
    if (rnd_wb && $urandom_range(0, 1) == 1)
      wb_drive(5'($urandom_range(0, 31)), $urandom);
    #1;
    chk({nm, ":read_ov"}, {31'b0, operandValid}, 32'd0);
    tick;
    wb_commit();
    for (int h = 0; h < hold; h++) begin
      if (rnd_wb && $urandom_range(0, 1) == 1)
        wb_drive(5'($urandom_range(0, 31)), $urandom);
      #1;
      chk({nm, ":hold_ov"}, {31'b0, operandValid}, 32'd1);
      chk({nm, ":hold_a"}, operandA, ea);
      chk({nm, ":hold_b"}, operandB, eb);
      tick;
      wb_commit();
    end
    operandReady = 1'b1;
    #1;
    chk({nm, ":ov"}, {31'b0, operandValid}, 32'd1);
    chk({nm, ":a"}, operandA, ea);
    chk({nm, ":b"}, operandB, eb);
    tick;
    operandReady = 1'b0;
    #1;
    chk({nm, ":done_ov"}, {31'b0, operandValid}, 32'd0);
  endtask

  initial begin
    logic [4:0]  ra, rb;
    logic [31:0] ea, eb;

    for (int i = 0; i < 32; i++) refm[i] = 32'h0;
    vecs[0] = '{5'd5,  32'h12345678, 5'd5, 5'd5,
                32'h12345678, 32'h12345678};
    vecs[1] = '{5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,
                32'h00000000, 32'h00000000};
    vecs[2] = '{5'd9,  32'hDEADBEEF, 5'd9, 5'd5,
                32'hDEADBEEF, 32'h12345678};
    vecs[3] = '{5'd31, 32'hCAFEF00D, 5'd0, 5'd31,
                32'h00000000, 32'hCAFEF00D};
    vecs[4] = '{5'd1,  32'h00000001, 5'd1, 5'd9,
                32'h00000001, 32'hDEADBEEF};

    reset          = 1'b1;
    fetchValid     = 1'b0;
    operandReady   = 1'b0;
    writebackValid = 1'b0;
    sourceIndexA   = '0;
    sourceIndexB   = '0;
    writebackIndex = '0;
    writebackData  = '0;
    tick;
    tick;
    chk("rst_ov", {31'b0, operandValid}, 32'd0);
    chk("rst_a", operandA, 32'd0);
    chk("rst_b", operandB, 32'd0);
    chk("rst_we", {31'b0, gprWriteEnable2}, 32'd0);
    chk("rst_wbr", {31'b0, writebackReady}, 32'd0);
    chk("rst_fr", {31'b0, fetchReady}, 32'd0);
    reset = 1'b0;
    tick;

    for (int v = 0; v < 5; v++) begin
      do_write(vecs[v].wi, vecs[v].wd);
      fetch_check(vecs[v].a, vecs[v].b, vecs[v].ea, vecs[v].eb,
                  0, 1'b0, $sformatf("vec%0d", v));
    end

    // Fetch and writeback collide: writeback wins, fetch issues next.
    fetchValid   = 1'b1;
    sourceIndexA = 5'd7;
    sourceIndexB = 5'd0;
    wb_drive(5'd7, 32'hA5A5A5A5);
    #1;
    chk("coll_fr", {31'b0, fetchReady}, 32'd0);
    chk("coll_we", {31'b0, gprWriteEnable2}, 32'd1);
    chk("coll_idx2", {27'b0, gprIndex2}, 32'd7);
    tick;
    wb_commit();
    fetchValid = 1'b0;
    fetch_check(5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 0, 1'b0, "coll");

    // Operands are a snapshot: later write to r3 must not leak in.
    fetchValid   = 1'b1;
    sourceIndexA = 5'd3;
    sourceIndexB = 5'd3;
    #1;
    tick;
    fetchValid = 1'b0;
    wb_drive(5'd3, 32'h00000001);
    tick;
    wb_commit();
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("hold_ov", {31'b0, operandValid}, 32'd1);
      chk("hold_a", operandA, 32'h0);
      tick;
    end
    operandReady = 1'b1;
    #1;
    chk("hold_rel_ov", {31'b0, operandValid}, 32'd1);
    tick;
    operandReady = 1'b0;
    #1;
    chk("hold_rel_done", {31'b0, operandValid}, 32'd0);
    fetch_check(5'd3, 5'd0, 32'h1, 32'h0, 0, 1'b0, "hold_new");

    // Back-to-back fetches with execute always ready.
    operandReady = 1'b1;
    fetchValid   = 1'b1;
    sourceIndexA = 5'd5;
    sourceIndexB = 5'd9;
    #1;
    chk("b2b_fr0", {31'b0, fetchReady}, 32'd1);
    tick;
    sourceIndexA = 5'd31;
    sourceIndexB = 5'd1;
    #1;
    chk("b2b_ov0", {31'b0, operandValid}, 32'd0);
    tick;
    #1;
    chk("b2b_ov1", {31'b0, operandValid}, 32'd1);
    chk("b2b_a1", operandA, 32'h12345678);
    chk("b2b_b1", operandB, 32'hDEADBEEF);
    chk("b2b_fr1", {31'b0, fetchReady}, 32'd1);
    tick;
    fetchValid = 1'b0;
    #1;
    chk("b2b_ov2", {31'b0, operandValid}, 32'd0);
    tick;
    #1;
    chk("b2b_ov3", {31'b0, operandValid}, 32'd1);
    chk("b2b_a2", operandA, 32'hCAFEF00D);
    chk("b2b_b2", operandB, 32'h00000001);
    tick;
    operandReady = 1'b0;
    #1;
    chk("b2b_idle", {31'b0, operandValid}, 32'd0);

    // Reset while in READ, with a writeback that must be dropped.
    fetchValid   = 1'b1;
    sourceIndexA = 5'd5;
    sourceIndexB = 5'd5;
    #1;
    tick;
    fetchValid = 1'b0;
    reset      = 1'b1;
    wb_drive(5'd12, 32'h77777777);
    #1;
    chk("rr_we", {31'b0, gprWriteEnable2}, 32'd0);
    chk("rr_wbr", {31'b0, writebackReady}, 32'd0);
    tick;
    wb_commit();
    #1;
    chk("rr_ov", {31'b0, operandValid}, 32'd0);
    reset = 1'b0;
    tick;
    chk("rr_ov2", {31'b0, operandValid}, 32'd0);
    fetch_check(5'd12, 5'd5, 32'h0, 32'h12345678, 0, 1'b0, "rr_chk");

    // Random traffic against the array model.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write(5'($urandom_range(0, 31)), $urandom);
      end else begin
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
        ea = model_rd(ra);
        eb = model_rd(rb);
        fetch_check(ra, rb, ea, eb, $urandom_range(0, 3), 1'b1, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
